// File: rtl/mcpu_ctrl_fsm_if.sv
// Memory/IO bus between the multi-cycle control sequencer and the memory port.
// master: sequencer side (issues requests, sees completion).
// slave : memory/IO side (answers with MIO_ready).
interface mcpu_ctrl_fsm_if;
    logic MIO_ready;
    logic CPU_MIO;
    logic MemRd;
    logic MemRW;
    logic IorD;

    modport master (
        input  MIO_ready,
        output CPU_MIO,
        output MemRd,
        output MemRW,
        output IorD
    );

    modport slave (
        output MIO_ready,
        input  CPU_MIO,
        input  MemRd,
        input  MemRW,
        input  IorD
    );
endinterface

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control sequencer for an RV32I subset (R-type, I-type ALU, lw,
// sw, beq, jal). Steps the shared ALU, memory port and register file through
// fetch/decode/execute/memory/write-back, waiting on MIO_ready for each access.
// Optional build macro MIO_TIMEOUT_EN: bounds every memory wait to
// TIMEOUT_CYCLES cycles and traps into BUS_ERR; without it waits are unbounded
// and bus_err is constant 0.
//
// state | meaning
// 0     | FETCH    : read instruction at PC, load IR/OldPC, PC <= PC+4
// 1     | DECODE   : branch/jump target into ALUOut, dispatch on opcode
// 2     | EXE_R    : reg-reg ALU op
// 3     | EXE_I    : reg-imm ALU op
// 4     | MEM_ADDR : effective address for lw/sw
// 5     | MEM_RD   : load data read, wait for MIO_ready
// 6     | MEM_WR   : store data write, wait for MIO_ready
// 7     | WB_ALU   : write ALUOut to rd
// 8     | WB_MEM   : write MDR to rd
// 9     | BRANCH   : compare, take branch when zero
// 10    | JAL      : rd <= PC (already PC+4), PC <= target
// 14    | ILLEGAL  : undecodable opcode, parked until reset
// 15    | BUS_ERR  : memory wait timed out, parked until reset
module mcpu_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            OPcode,
    input  logic [2:0]            Fun3,
    input  logic                  Fun7,
    input  logic                  zero,
    mcpu_ctrl_fsm_if.master       bus,
    output logic                  PCWrite,
    output logic                  PCSource,
    output logic                  IRWrite,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSel,
    output logic [2:0]            ALU_Control,
    output logic                  RegWrite,
    output logic [1:0]            MemtoReg,
    output logic                  instr_done,
    output logic                  illegal,
    output logic                  bus_err,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd14,
        S_BUS_ERR  = 4'd15
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t r_state;
    state_t w_next;
    logic   w_timeout;
    logic   w_iord;
    logic   w_mem_rd;
    logic   w_mem_rw;
    logic   w_cpu_mio;

    // {Fun7,Fun3} to ALU operation; unsupported combinations fall back to and
    function automatic logic [2:0] f_alu(input logic [3:0] funct);
        case (funct)
            4'b0000: f_alu = ALU_ADD;
            4'b1000: f_alu = ALU_SUB;
            4'b0111: f_alu = ALU_AND;
            4'b0110: f_alu = ALU_OR;
            4'b0010: f_alu = ALU_SLT;
            4'b0101: f_alu = ALU_SRL;
            4'b0100: f_alu = ALU_XOR;
            default: f_alu = ALU_AND;
        endcase
    endfunction

`ifdef MIO_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_wait_cnt;
    logic          w_waiting;

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    // A ready on the limit cycle still completes the access normally
    assign w_timeout = w_waiting && !bus.MIO_ready && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Wait-state counter: cleared whenever the state changes, counts idle bus cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !bus.MIO_ready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset abandons any access and restarts with a fresh fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control decode; everything is held at 0 while in reset
    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        PCSource    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSel      = 2'b00;
        ALU_Control = ALU_AND;
        RegWrite    = 1'b0;
        MemtoReg    = 2'b00;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        w_iord      = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_rw    = 1'b0;
        w_cpu_mio   = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    w_mem_rd  = 1'b1;
                    w_cpu_mio = 1'b1;
                    if (bus.MIO_ready) begin
                        IRWrite     = 1'b1;
                        PCWrite     = 1'b1;
                        ALUSrcB     = 2'b01;
                        ALU_Control = ALU_ADD;
                        w_next      = S_DECODE;
                    end else if (w_timeout) begin
                        w_next = S_BUS_ERR;
                    end
                end
                S_DECODE: begin
                    ALUSrcA     = 2'b01;
                    ALUSrcB     = 2'b10;
                    ALU_Control = ALU_ADD;
                    ImmSel      = (OPcode == 5'b11000) ? 2'b10 :
                                  (OPcode == 5'b11011) ? 2'b11 : 2'b00;
                    case (OPcode)
                        5'b01100:          w_next = S_EXE_R;
                        5'b00100:          w_next = S_EXE_I;
                        5'b00000, 5'b01000: w_next = S_MEM_ADDR;
                        5'b11000:          w_next = S_BRANCH;
                        5'b11011:          w_next = S_JAL;
                        default:           w_next = S_ILLEGAL;
                    endcase
                end
                S_EXE_R: begin
                    ALUSrcA     = 2'b10;
                    ALU_Control = f_alu({Fun7, Fun3});
                    w_next      = S_WB_ALU;
                end
                S_EXE_I: begin
                    ALUSrcA     = 2'b10;
                    ALUSrcB     = 2'b10;
                    ALU_Control = f_alu({1'b0, Fun3});
                    w_next      = S_WB_ALU;
                end
                S_MEM_ADDR: begin
                    ALUSrcA     = 2'b10;
                    ALUSrcB     = 2'b10;
                    ALU_Control = ALU_ADD;
                    ImmSel      = (OPcode == 5'b01000) ? 2'b01 : 2'b00;
                    w_next      = (OPcode == 5'b01000) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    w_iord    = 1'b1;
                    w_mem_rd  = 1'b1;
                    w_cpu_mio = 1'b1;
                    if (bus.MIO_ready) begin
                        w_next = S_WB_MEM;
                    end else if (w_timeout) begin
                        w_next = S_BUS_ERR;
                    end
                end
                S_MEM_WR: begin
                    w_iord    = 1'b1;
                    w_mem_rw  = 1'b1;
                    w_cpu_mio = 1'b1;
                    if (bus.MIO_ready) begin
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end else if (w_timeout) begin
                        w_next = S_BUS_ERR;
                    end
                end
                S_WB_ALU: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_WB_MEM: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b01;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 2'b10;
                    ALU_Control = ALU_SUB;
                    PCWrite     = zero;
                    PCSource    = 1'b1;
                    instr_done  = 1'b1;
                    w_next      = S_FETCH;
                end
                S_JAL: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 2'b10;
                    PCWrite    = 1'b1;
                    PCSource   = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                S_BUS_ERR: begin
`ifdef MIO_TIMEOUT_EN
                    bus_err = 1'b1;
`endif
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

    assign bus.IorD    = w_iord;
    assign bus.MemRd   = w_mem_rd;
    assign bus.MemRW   = w_mem_rw;
    assign bus.CPU_MIO = w_cpu_mio;
    assign state       = rst_n ? r_state : 4'd0;

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Bench for mcpu_ctrl_fsm: each scenario queues one expected output vector and
// one stimulus word ({rst_n, MIO_ready, zero}) per cycle, then drains the queues,
// comparing all outputs at the falling edge.
module tb_mcpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       zero;
    logic       PCWrite, PCSource, IRWrite, RegWrite, instr_done, illegal, bus_err;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSel, MemtoReg;
    logic [2:0] ALU_Control;
    logic [3:0] state;

    mcpu_ctrl_fsm_if bus();

    mcpu_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OPcode     (OPcode),
        .Fun3       (Fun3),
        .Fun7       (Fun7),
        .zero       (zero),
        .bus        (bus),
        .PCWrite    (PCWrite),
        .PCSource   (PCSource),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSel     (ImmSel),
        .ALU_Control(ALU_Control),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .instr_done (instr_done),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, pcs, irw, iord, mrd, mrw, mio;
        logic [1:0] asa, asb, imm;
        logic [2:0] alu;
        logic       rw;
        logic [1:0] m2r;
        logic       done, ill, berr;
        logic [3:0] st;
    } ov_t;

    ov_t w_got;
    assign w_got = {PCWrite, PCSource, IRWrite, bus.IorD, bus.MemRd, bus.MemRW, bus.CPU_MIO,
                    ALUSrcA, ALUSrcB, ImmSel, ALU_Control, RegWrite, MemtoReg,
                    instr_done, illegal, bus_err, state};

    int         n_vec  = 0;
    int         n_miss = 0;
    ov_t        exp_q[$];
    logic [2:0] stim_q[$];

    function automatic void put(input ov_t e, input logic r, input logic rdy, input logic z);
        exp_q.push_back(e);
        stim_q.push_back({r, rdy, z});
    endfunction

    // Expected vectors per state, straight from the control table
    function automatic ov_t f_fetch(input logic rdy);
        ov_t x = '0;
        x.mrd = 1'b1; x.mio = 1'b1;
        if (rdy) begin x.irw = 1'b1; x.pcw = 1'b1; x.asb = 2'b01; x.alu = 3'b010; end
        return x;
    endfunction
    function automatic ov_t f_decode(input logic [1:0] imm);
        ov_t x = '0;
        x.st = 4'd1; x.asa = 2'b01; x.asb = 2'b10; x.alu = 3'b010; x.imm = imm;
        return x;
    endfunction
    function automatic ov_t f_exe_r(input logic [2:0] alu);
        ov_t x = '0;
        x.st = 4'd2; x.asa = 2'b10; x.asb = 2'b00; x.alu = alu;
        return x;
    endfunction
    function automatic ov_t f_exe_i(input logic [2:0] alu);
        ov_t x = '0;
        x.st = 4'd3; x.asa = 2'b10; x.asb = 2'b10; x.alu = alu;
        return x;
    endfunction
    function automatic ov_t f_mem_addr(input logic [1:0] imm);
        ov_t x = '0;
        x.st = 4'd4; x.asa = 2'b10; x.asb = 2'b10; x.alu = 3'b010; x.imm = imm;
        return x;
    endfunction
    function automatic ov_t f_mem_rd();
        ov_t x = '0;
        x.st = 4'd5; x.iord = 1'b1; x.mrd = 1'b1; x.mio = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_mem_wr(input logic rdy);
        ov_t x = '0;
        x.st = 4'd6; x.iord = 1'b1; x.mrw = 1'b1; x.mio = 1'b1; x.done = rdy;
        return x;
    endfunction
    function automatic ov_t f_wb_alu();
        ov_t x = '0;
        x.st = 4'd7; x.rw = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_wb_mem();
        ov_t x = '0;
        x.st = 4'd8; x.rw = 1'b1; x.m2r = 2'b01; x.done = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_branch(input logic z);
        ov_t x = '0;
        x.st = 4'd9; x.asa = 2'b10; x.alu = 3'b110; x.pcw = z; x.pcs = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_jal();
        ov_t x = '0;
        x.st = 4'd10; x.rw = 1'b1; x.m2r = 2'b10; x.pcw = 1'b1; x.pcs = 1'b1; x.done = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_ill();
        ov_t x = '0;
        x.st = 4'd14; x.ill = 1'b1;
        return x;
    endfunction
    function automatic ov_t f_berr();
        ov_t x = '0;
        x.st = 4'd15; x.berr = 1'b1;
        return x;
    endfunction

    task automatic test_reset();
        ov_t e; logic [2:0] s;
        OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0;
        put('0, 1'b0, 1'b1, 1'b1);
        put('0, 1'b0, 1'b1, 1'b0);
        put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL reset: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r_type();
        ov_t e; logic [2:0] s;
        logic [6:0] tbl [8] = '{{1'b0, 3'b000, 3'b010}, {1'b1, 3'b000, 3'b110},
                                {1'b0, 3'b111, 3'b000}, {1'b0, 3'b110, 3'b001},
                                {1'b0, 3'b010, 3'b111}, {1'b0, 3'b101, 3'b101},
                                {1'b0, 3'b100, 3'b011}, {1'b1, 3'b111, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            OPcode = 5'b01100; Fun7 = tbl[i][6]; Fun3 = tbl[i][5:3];
            put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
            put(f_decode(2'b00), 1'b1, 1'b0, 1'b1);
            put(f_exe_r(tbl[i][2:0]), 1'b1, 1'b1, 1'b0);
            put(f_wb_alu(), 1'b1, 1'b1, 1'b0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); s = stim_q.pop_front();
                rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
                @(negedge clk); n_vec++;
                if (w_got !== e) begin
                    n_miss++;
                    $display("FAIL r_type[%0d]: got %h (state %0d) expected %h (state %0d)", i, w_got, w_got.st, e, e.st);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_i_type();
        ov_t e; logic [2:0] s;
        logic [6:0] tbl [4] = '{{1'b1, 3'b000, 3'b010}, {1'b0, 3'b010, 3'b111},
                                {1'b1, 3'b101, 3'b101}, {1'b0, 3'b100, 3'b011}};
        for (int i = 0; i < 4; i++) begin
            OPcode = 5'b00100; Fun7 = tbl[i][6]; Fun3 = tbl[i][5:3];
            put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
            put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
            put(f_exe_i(tbl[i][2:0]), 1'b1, 1'b0, 1'b0);
            put(f_wb_alu(), 1'b1, 1'b0, 1'b0);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); s = stim_q.pop_front();
                rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
                @(negedge clk); n_vec++;
                if (w_got !== e) begin
                    n_miss++;
                    $display("FAIL i_type[%0d]: got %h (state %0d) expected %h (state %0d)", i, w_got, w_got.st, e, e.st);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mem();
        ov_t e; logic [2:0] s;
        // lw with three wait cycles in MEM_RD: 8 cycles total
        OPcode = 5'b00000; Fun3 = 3'b010; Fun7 = 1'b0;
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b00), 1'b1, 1'b1, 1'b0);
        put(f_mem_addr(2'b00), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) put(f_mem_rd(), 1'b1, 1'b0, 1'b0);
        put(f_mem_rd(), 1'b1, 1'b1, 1'b0);
        put(f_wb_mem(), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL lw: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
        // sw with one fetch wait and two write waits
        OPcode = 5'b01000;
        put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_mem_addr(2'b01), 1'b1, 1'b0, 1'b0);
        put(f_mem_wr(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_mem_wr(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_mem_wr(1'b1), 1'b1, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL sw: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jal();
        ov_t e; logic [2:0] s;
        OPcode = 5'b11000; Fun3 = 3'b000; Fun7 = 1'b0;
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b10), 1'b1, 1'b0, 1'b0);
        put(f_branch(1'b1), 1'b1, 1'b0, 1'b1);
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b1);
        put(f_decode(2'b10), 1'b1, 1'b0, 1'b1);
        put(f_branch(1'b0), 1'b1, 1'b1, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL beq: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
        OPcode = 5'b11011;
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b11), 1'b1, 1'b0, 1'b0);
        put(f_jal(), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL jal: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        ov_t e; logic [2:0] s;
        OPcode = 5'b11111; Fun3 = 3'b000; Fun7 = 1'b0;
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) put(f_ill(), 1'b1, 1'b1, 1'b1);
        put('0, 1'b0, 1'b1, 1'b0);
        put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL illegal: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_access();
        ov_t e; logic [2:0] s;
        OPcode = 5'b00000; Fun3 = 3'b010; Fun7 = 1'b0;
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_mem_addr(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_mem_rd(), 1'b1, 1'b0, 1'b0);
        put(f_mem_rd(), 1'b1, 1'b0, 1'b0);
        put('0, 1'b0, 1'b1, 1'b0);
        put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
        put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_mem_addr(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_mem_rd(), 1'b1, 1'b1, 1'b0);
        put(f_wb_mem(), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL reset_mid: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        ov_t e; logic [2:0] s;
        OPcode = 5'b01100; Fun3 = 3'b000; Fun7 = 1'b0;
`ifdef MIO_TIMEOUT_EN
        for (int i = 0; i < 16; i++) put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_berr(), 1'b1, 1'b1, 1'b0);
        put(f_berr(), 1'b1, 1'b0, 1'b0);
        put('0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) put(f_fetch(1'b0), 1'b1, 1'b0, 1'b0);
        put(f_fetch(1'b1), 1'b1, 1'b1, 1'b0);
`endif
        put(f_decode(2'b00), 1'b1, 1'b0, 1'b0);
        put(f_exe_r(3'b010), 1'b1, 1'b0, 1'b0);
        put(f_wb_alu(), 1'b1, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); s = stim_q.pop_front();
            rst_n = s[2]; bus.MIO_ready = s[1]; zero = s[0];
            @(negedge clk); n_vec++;
            if (w_got !== e) begin
                n_miss++;
                $display("FAIL timeout: got %h (state %0d) expected %h (state %0d)", w_got, w_got.st, e, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.MIO_ready = 1'b0; zero = 1'b0;
        OPcode = 5'b0; Fun3 = 3'b0; Fun7 = 1'b0;
        test_reset();
        test_r_type();
        test_i_type();
        test_mem();
        test_branch_jal();
        test_illegal();
        test_reset_mid_access();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, vectors %0d", n_vec);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mcpu_ctrl_fsm.md
Name: mcpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I subset (add/sub/and/or/slt/srl/xor, addi/slti-class, lw, sw, beq, jal).
- Replaces the single-cycle decoder: steps the shared ALU, memory port and register file through FETCH/DECODE/EXECUTE/MEM/WB states.
- Waits on MIO_ready for every memory access.
- Sits between the instruction register and the multi-cycle datapath (PC, OldPC, IR, A/B, ALUOut, MDR registers).

Parameters:
- TIMEOUT_CYCLES, 16, MIO wait-state limit before a bus error is raised (used only with MIO_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- OPcode  in  5  IR[6:2].
- Fun3  in  3  IR[14:12].
- Fun7  in  1  IR[30].
- zero  in  1  ALU zero flag (combinational, current cycle).
- MIO_ready  in  1  memory/IO access complete this cycle.
- PCWrite  out  1  load PC.
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC (OldPC gets the current PC).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRd  out  1  memory read request.
- MemRW  out  1  memory write request (1 = write).
- CPU_MIO  out  1  bus request valid.
- ALUSrcA  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = reg A.
- ALUSrcB  out  2  ALU B input: 00 = reg B, 01 = const 4, 10 = imm.
- ImmSel  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALU_Control  out  3  and 000, or 001, add 010, xor 011, srl 101, sub 110, slt 111.
- RegWrite  out  1  register file write.
- MemtoReg  out  2  write-back source: 00 = ALU, 01 = MDR, 10 = PC (already PC+4).
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  sticky: undecodable opcode seen.
- bus_err  out  1  sticky: MIO timeout (tied 0 without MIO_TIMEOUT_EN).
- state  out  4  current state, for debug.

Behaviour:
- State is registered; all outputs are Moore/Mealy decode of state (plus MIO_ready/zero where stated).
- Any output not listed for a state is 0.
- Reset: while rst_n=0 every output is forced to 0. The next state after release is FETCH (0).
- Reset mid-access abandons the access; the first post-reset cycle issues a fresh fetch.
- Funct decode ({Fun7,Fun3}) maps to ALU_Control: 0000 add, 1000 sub, 0111 and, 0110 or, 0010 slt, 0101 srl, 0100 xor, other → and.
- FETCH(0): MemRd=1, CPU_MIO=1, IorD=0.
  - If MIO_ready: IRWrite=1, PCWrite=1, PCSource=0, ALUSrcA=00, ALUSrcB=01, ALU add; go to DECODE.
  - Else stay in FETCH.
- DECODE(1): ALUSrcA=01, ALUSrcB=10, ALU add (branch/jump target into ALUOut). ImmSel=B for 11000, J for 11011, else I. Next state by opcode:
  - 01100 → EXE_R
  - 00100 → EXE_I
  - 00000 or 01000 → MEM_ADDR
  - 11000 → BRANCH
  - 11011 → JAL
  - other → ILLEGAL
- EXE_R(2): ALUSrcA=10, ALUSrcB=00, funct decode → WB_ALU.
- EXE_I(3): ALUSrcA=10, ALUSrcB=10, ImmSel=I, funct decode with Fun7 treated as 0 → WB_ALU.
- MEM_ADDR(4): ALUSrcA=10, ALUSrcB=10, add. ImmSel=S if OPcode=01000, else I. Next: MEM_WR for sw, MEM_RD for lw.
- MEM_RD(5): IorD=1, MemRd=1, CPU_MIO=1. Stay until MIO_ready, then → WB_MEM.
- MEM_WR(6): IorD=1, MemRW=1, CPU_MIO=1. Stay until MIO_ready, then instr_done=1 → FETCH.
- WB_ALU(7): RegWrite=1, MemtoReg=00, instr_done=1 → FETCH.
- WB_MEM(8): RegWrite=1, MemtoReg=01, instr_done=1 → FETCH.
- BRANCH(9): ALUSrcA=10, ALUSrcB=00, sub. PCWrite=zero, PCSource=1, instr_done=1 → FETCH.
- JAL(10): RegWrite=1, MemtoReg=10, PCWrite=1, PCSource=1, instr_done=1 → FETCH.
- ILLEGAL(14): illegal=1; no writes or requests; held until reset.
- BUS_ERR(15): bus_err=1; no writes or requests; held until reset.
- MIO_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Latency: R/I = 4 cycles, lw = 5, sw = 4, beq = 3, jal = 3 (each memory wait cycle adds 1).

Optional Feature:
- MIO_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle MIO_ready=0 in those states.
  - When the count equals TIMEOUT_CYCLES-1 and MIO_ready is still 0, go to BUS_ERR.
  - MIO_ready arriving on that same cycle wins: the access completes normally.
- Not defined: no counter; waits forever; bus_err is constant 0.

Test Plan:
- add x3,x1,x2 (OPcode 01100, Fun3 000, Fun7 0), MIO_ready=1 → states 0,1,2,7. EXE_R ALU_Control=010; WB_ALU RegWrite=1; instr_done on cycle 4 only.
- lw with MIO_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with MemRd=IorD=CPU_MIO=1, then WB_MEM with MemtoReg=01; total 8 cycles.
- beq with zero=1, then zero=0 → PCWrite=1/PCSource=1 in BRANCH only when zero=1; ALU_Control=110 both times.
- jal → DECODE ImmSel=11; JAL cycle RegWrite=1, MemtoReg=10, PCWrite=1; 3 cycles.
- OPcode 11111 → ILLEGAL after DECODE; illegal=1 sticky; no PCWrite/RegWrite/CPU_MIO; rst_n=0 for one cycle → all outputs 0, then FETCH.
- MIO_TIMEOUT_EN, TIMEOUT_CYCLES=16, MIO_ready held 0 in FETCH → bus_err=1 after 16 cycles. Repeat with ready on cycle 16 → normal DECODE.
